iter_alu: RTL and testbench

- Parametrised, multi-cycle successor to the datapath's single-cycle ALU.
- Keeps the existing ALUctr encoding for add, sub, and or. Adds and, slt, pass-B, an iterative unsigned multiply and an iterative unsigned divide.
- Operations launch with a start/busy/done handshake, and results are registered.
- Sits in the EX stage of the multi-cycle CPU datapath. The control unit stalls on busy.

---
 rtl/iter_alu_if.sv | 28 ++
 rtl/iter_alu.sv | 166 ++++++++++++++++
 tb/tb_iter_alu.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/iter_alu_if.sv
// Operand/result bundle for iter_alu: the CPU control side (master) issues
// start/A/B/ALUctr, and the ALU (slave) returns registered results and handshake.
interface iter_alu_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       ALUctr;
  logic [WIDTH-1:0] ALU;
  logic [WIDTH-1:0] ALU_hi;
  logic             Zero;
  logic             carrier;
  logic             overflow;
  logic             div0;
  logic             busy;
  logic             done;

  modport master (
    output start, A, B, ALUctr,
    input  ALU, ALU_hi, Zero, carrier, overflow, div0, busy, done
  );

  modport slave (
    input  start, A, B, ALUctr,
    output ALU, ALU_hi, Zero, carrier, overflow, div0, busy, done
  );
endinterface

// File: rtl/iter_alu.sv
// Multi-cycle EX-stage ALU: single-cycle add/sub/or/and/slt/pass-B plus iterative
// unsigned shift-add multiply and restoring divide behind a start/busy/done handshake.
module iter_alu #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input logic       clk,
  input logic       rst_n,
  iter_alu_if.slave bus
);
  localparam int unsigned MSB = WIDTH - 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;

  localparam logic [2:0] OP_AND   = 3'b000;
  localparam logic [2:0] OP_OR    = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_MUL   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_PASSB = 3'b101;
  localparam logic [2:0] OP_SUB   = 3'b110;
  localparam logic [2:0] OP_SLT   = 3'b111;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] lo;

  logic [WIDTH-1:0] alu_q;
  logic [WIDTH-1:0] alu_hi_q;
  logic             zero_q;
  logic             carry_q;
  logic             ovf_q;
  logic             div0_q;
  logic             busy_q;
  logic             done_q;

  logic [WIDTH:0]   add_w;
  logic [WIDTH:0]   sub_w;
  logic [WIDTH-1:0] sc_res;
  logic             sc_c;
  logic             sc_v;

  logic [WIDTH:0]   msum;
  logic [WIDTH:0]   dshift;
  logic [WIDTH:0]   ddiff;
  logic [WIDTH-1:0] nxt_acc;
  logic [WIDTH-1:0] nxt_lo;
  logic             last;

  always_comb begin
    add_w  = {1'b0, bus.A} + {1'b0, bus.B};
    sub_w  = {1'b0, bus.A} - {1'b0, bus.B};
    sc_res = '0;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    case (bus.ALUctr)
      OP_ADD: begin
        sc_res = add_w[MSB:0];
        sc_c   = add_w[WIDTH];
        sc_v   = (bus.A[MSB] == bus.B[MSB]) && (add_w[MSB] != bus.A[MSB]);
      end
      OP_SUB: begin
        sc_res = sub_w[MSB:0];
        sc_c   = sub_w[WIDTH];
        sc_v   = (bus.A[MSB] != bus.B[MSB]) && (sub_w[MSB] != bus.A[MSB]);
      end
      OP_OR:    sc_res = bus.A | bus.B;
      OP_AND:   sc_res = bus.A & bus.B;
      OP_SLT:   sc_res = WIDTH'($signed(bus.A) < $signed(bus.B));
      OP_PASSB: sc_res = bus.B;
      default:  sc_res = '0;
    endcase
  end

  // acc/lo are shared: {hi,multiplier} for mul, {remainder,dividend} for div.
  // opnd holds the multiplicand or the divisor.
  always_comb begin
    msum    = {1'b0, acc} + (lo[0] ? {1'b0, opnd} : '0);
    dshift  = {acc, lo[MSB]};
    ddiff   = dshift - {1'b0, opnd};
    nxt_acc = '0;
    nxt_lo  = '0;
    if (state == S_MUL) begin
      nxt_acc = msum[WIDTH:1];
      nxt_lo  = {msum[0], lo[MSB:1]};
    end else begin
      nxt_acc = ddiff[WIDTH] ? dshift[MSB:0] : ddiff[MSB:0];
      nxt_lo  = {lo[MSB-1:0], ~ddiff[WIDTH]};
    end
    last = (cnt == CNT_W'(WIDTH - 1));
  end

  // A zero divisor never borrows, so the restoring loop itself yields
  // quotient all-ones and remainder equal to the dividend.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      opnd     <= '0;
      acc      <= '0;
      lo       <= '0;
      alu_q    <= '0;
      alu_hi_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      div0_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            if (bus.ALUctr == OP_MUL || bus.ALUctr == OP_DIVU) begin
              opnd   <= (bus.ALUctr == OP_MUL) ? bus.A : bus.B;
              lo     <= (bus.ALUctr == OP_MUL) ? bus.B : bus.A;
              acc    <= '0;
              cnt    <= '0;
              busy_q <= 1'b1;
              state  <= (bus.ALUctr == OP_MUL) ? S_MUL : S_DIV;
            end else begin
              alu_q    <= sc_res;
              alu_hi_q <= '0;
              zero_q   <= (sc_res == '0);
              carry_q  <= sc_c;
              ovf_q    <= sc_v;
              div0_q   <= 1'b0;
              done_q   <= 1'b1;
            end
          end
        end
        S_MUL, S_DIV: begin
          acc <= nxt_acc;
          lo  <= nxt_lo;
          cnt <= cnt + CNT_W'(1);
          if (last) begin
            alu_q    <= nxt_lo;
            alu_hi_q <= nxt_acc;
            zero_q   <= (nxt_lo == '0);
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            div0_q   <= (state == S_DIV) && (opnd == '0);
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.ALU      = alu_q;
  assign bus.ALU_hi   = alu_hi_q;
  assign bus.Zero     = zero_q;
  assign bus.carrier  = carry_q;
  assign bus.overflow = ovf_q;
  assign bus.div0     = div0_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
endmodule

// File: tb/tb_iter_alu.sv
// Scoreboard bench for iter_alu: directed vectors push hand-computed results,
// a negedge monitor pops and compares on every done pulse.
module tb_iter_alu;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  iter_alu_if #(.WIDTH(32)) bus ();

  iter_alu #(.WIDTH(32), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [7:0]  id;
    logic [31:0] alu;
    logic [31:0] hi;
    logic        z;
    logic        c;
    logic        v;
    logic        d0;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, expv);
    end
  endtask

  task automatic push(input logic [7:0] id, input logic [31:0] alu, input logic [31:0] hi,
                      input logic z, input logic c, input logic v, input logic d0);
    exp_t e;
    e.id = id; e.alu = alu; e.hi = hi; e.z = z; e.c = c; e.v = v; e.d0 = d0;
    exp_q.push_back(e);
  endtask

  // Called at #1 after a rising edge; start is seen by the next edge only.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.ALUctr = op;
    bus.A      = a;
    bus.B      = b;
    bus.start  = 1'b1;
    @(posedge clk); #1;
    bus.start  = 1'b0;
  endtask

  // Returns number of edges after acceptance until done is visible.
  task automatic wait_done(input string nm, output int n);
    n = 0;
    while (!bus.done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.done) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: done not seen within 100 cycles", nm);
    end
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.done) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_done: ALU=0x%08h with no pending transaction", bus.ALU);
        end else begin
          e = exp_q.pop_front();
          if ({bus.ALU, bus.ALU_hi, bus.Zero, bus.carrier, bus.overflow, bus.div0} !==
              {e.alu, e.hi, e.z, e.c, e.v, e.d0}) begin
            n_fail++;
            $display("FAIL txn%0d: got ALU=%08h hi=%08h Z=%b C=%b V=%b d0=%b expected ALU=%08h hi=%08h Z=%b C=%b V=%b d0=%b",
                     e.id, bus.ALU, bus.ALU_hi, bus.Zero, bus.carrier, bus.overflow, bus.div0,
                     e.alu, e.hi, e.z, e.c, e.v, e.d0);
          end
        end
      end
    end
  end

  initial begin
    int n;
    bus.start = 1'b0; bus.A = '0; bus.B = '0; bus.ALUctr = 3'b000;

    // Reset state
    repeat (2) @(posedge clk); #1;
    chk("reset_outputs", {bus.ALU[15:0], bus.ALU_hi[11:0], bus.Zero, bus.carrier, bus.overflow, bus.div0},
        32'h0);
    chk("reset_hs", {30'h0, bus.busy, bus.done}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Mid-operation reset on mul 3*5: aborted, no done afterwards
    issue(3'b011, 32'd3, 32'd5);
    repeat (9) begin @(posedge clk); #1; end
    chk("midop_busy", {31'h0, bus.busy}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("midop_rst_alu", bus.ALU | bus.ALU_hi, 32'h0);
    chk("midop_rst_flags", {26'h0, bus.Zero, bus.carrier, bus.overflow, bus.div0, bus.busy, bus.done}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (40) begin @(posedge clk); #1; end
    chk("midop_after_busy", {31'h0, bus.busy}, 32'h0);

    // Single-cycle ops, back to back
    push(8'd1, 32'h0000_0000, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    issue(3'b010, 32'hFFFF_FFFF, 32'h1);
    push(8'd2, 32'h8000_0000, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    issue(3'b010, 32'h7FFF_FFFF, 32'h1);
    push(8'd3, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    issue(3'b110, 32'h1, 32'h2);
    push(8'd4, 32'h0000_0001, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(3'b111, 32'hFFFF_FFFF, 32'h1);
    push(8'd5, 32'h7FFF_FFFF, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    issue(3'b110, 32'h8000_0000, 32'h1);
    push(8'd6, 32'h0000_0030, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(3'b000, 32'hF0, 32'h3C);
    push(8'd7, 32'h0000_0000, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    issue(3'b101, 32'h1234, 32'h0);
    push(8'd8, 32'h0000_0000, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    issue(3'b111, 32'h5, 32'hFFFF_FFFB);
    @(posedge clk); #1;

    // mul 0xFFFFFFFF^2 with an ignored start at cycle 5 and input churn
    push(8'd9, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("mul_busy_start", {31'h0, bus.busy}, 32'h1);
    n = 0;
    while (!bus.done && n < 100) begin
      if (n == 4) begin bus.start = 1'b1; bus.ALUctr = 3'b010; bus.A = 32'h1; bus.B = 32'h1; end
      @(posedge clk); #1;
      n++;
      if (n == 5) bus.start = 1'b0;
      if (n == 16) chk("mul_busy_mid", {31'h0, bus.busy}, 32'h1);
    end
    chk("mul_latency", n, 32'd32);
    chk("mul_busy_end", {31'h0, bus.busy}, 32'h0);
    @(posedge clk); #1;

    // divu 100/7, chained with or in the done cycle
    push(8'd10, 32'd14, 32'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(3'b100, 32'd100, 32'd7);
    wait_done("div_wait", n);
    chk("div_latency", n, 32'd32);
    push(8'd11, 32'h0000_00FF, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(3'b001, 32'hF0, 32'h0F);
    chk("chain_done", {31'h0, bus.done}, 32'h1);
    chk("chain_alu", bus.ALU, 32'hFF);
    @(posedge clk); #1;

    // Divide by zero, then a mul that must clear div0
    push(8'd12, 32'hFFFF_FFFF, 32'h1234, 1'b0, 1'b0, 1'b0, 1'b1);
    issue(3'b100, 32'h1234, 32'h0);
    wait_done("div0_wait", n);
    chk("div0_latency", n, 32'd32);
    @(posedge clk); #1;
    push(8'd13, 32'd15, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    issue(3'b011, 32'd3, 32'd5);
    wait_done("mul2_wait", n);
    @(posedge clk); #1;
    push(8'd14, 32'h0000_0000, 32'h0000_0005, 1'b1, 1'b0, 1'b0, 1'b0);
    issue(3'b100, 32'd5, 32'd9);
    wait_done("div2_wait", n);
    repeat (3) begin @(posedge clk); #1; end

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
